// File: rtl/uart_rx_sniffer.sv
// 8N1 UART receiver (8E1 when UART_RX_SNIFFER_PARITY_EN is defined) with framing/overrun/parity flags.
// Latency: byte valid ~2 + DIV/2 + 9*DIV + 1 clocks after the start edge (+DIV with parity).
// Backpressure: single-entry output register; a good byte arriving while full is dropped and overrun_o pulses.
module uart_rx_sniffer #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115_200
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       busy_o,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       parity_err_o
);

   localparam int DIV = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int DW  = $clog2(DIV + 1);
   // The expiry cycle itself is one count, so loads are one short of the interval.
   localparam logic [DW-1:0] FULL_LD = DW'(DIV - 1);
   localparam logic [DW-1:0] HALF_LD = DW'(DIV / 2 - 1);

`ifdef UART_RX_SNIFFER_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic par_bad;
   logic par_pulse;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state;
   logic            rx_s1, rx_s2, rx_prev;
   logic [DW-1:0]   div;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            expire;

   assign expire = (div == '0);
   assign busy_o = (state != IDLE);

`ifdef UART_RX_SNIFFER_PARITY_EN
   assign parity_err_o = par_pulse;
`else
   assign parity_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_s1       <= 1'b1;
         rx_s2       <= 1'b1;
         rx_prev     <= 1'b1;
         state       <= IDLE;
         div         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
`ifdef UART_RX_SNIFFER_PARITY_EN
         par_bad     <= 1'b0;
         par_pulse   <= 1'b0;
`endif
      end else begin
         rx_s1       <= rx_i;
         rx_s2       <= rx_s1;
         rx_prev     <= rx_s2;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
`ifdef UART_RX_SNIFFER_PARITY_EN
         par_pulse   <= 1'b0;
`endif
         if (valid_o && ready_i)
            valid_o <= 1'b0;

         if (state != IDLE && !expire)
            div <= div - 1'b1;

         case (state)
            IDLE: begin
               // Requires a high-to-low transition, so a held-low break never retriggers.
               if (rx_prev && !rx_s2) begin
                  div   <= HALF_LD;
                  state <= START;
               end
            end
            START: begin
               if (expire) begin
                  if (!rx_s2) begin
                     div     <= FULL_LD;
                     bit_idx <= '0;
                     state   <= DATA;
`ifdef UART_RX_SNIFFER_PARITY_EN
                     par_bad <= 1'b0;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               if (expire) begin
                  shreg[bit_idx] <= rx_s2;
                  div            <= FULL_LD;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_SNIFFER_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
`ifdef UART_RX_SNIFFER_PARITY_EN
            PARITY: begin
               if (expire) begin
                  par_bad <= (rx_s2 != ^shreg);
                  div     <= FULL_LD;
                  state   <= STOP;
               end
            end
`endif
            STOP: begin
               // Leave at mid-stop so a back-to-back start edge is never missed.
               if (expire) begin
                  state <= IDLE;
                  if (!rx_s2) begin
                     frame_err_o <= 1'b1;
`ifdef UART_RX_SNIFFER_PARITY_EN
                  end else if (par_bad) begin
                     par_pulse <= 1'b1;
`endif
                  end else if (!valid_o || ready_i) begin
                     data_o  <= shreg;
                     valid_o <= 1'b1;
                  end else begin
                     overrun_o <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Directed bench for uart_rx_sniffer at DIV=8: frame-level outcome model plus per-cycle output checks.
module tb_uart_rx_sniffer;

   localparam int DIV = 8;
`ifdef UART_RX_SNIFFER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int K_DEL  = 0;
   localparam int K_OVR  = 1;
   localparam int K_FERR = 2;
   localparam int K_PERR = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       ready;
   logic [7:0] data;
   logic       valid, busy, ferr, ovr, perr;

   always #5 clk = ~clk;

   uart_rx_sniffer #(
      .CLK_FREQ_HZ(100_000_000),
      .BAUD_RATE  (12_500_000)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rx_i        (rx),
      .data_o      (data),
      .valid_o     (valid),
      .ready_i     (ready),
      .busy_o      (busy),
      .frame_err_o (ferr),
      .overrun_o   (ovr),
      .parity_err_o(perr)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t_start = 0;
   int last_del_cyc = 0;
   int cnt_del = 0, cnt_ovr = 0, cnt_ferr = 0, cnt_perr = 0;
   int exp_kind[$];
   logic [7:0] exp_dat[$];
   bit m_full = 1'b0;
   bit run_chk = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_evt(input int kind, input logic [7:0] d);
      int k;
      logic [7:0] ed;
      checks++;
      if (exp_kind.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event: got kind %0d data %0h, expected no event", kind, d);
      end else begin
         k  = exp_kind.pop_front();
         ed = exp_dat.pop_front();
         if (k != kind || (kind == K_DEL && ed !== d)) begin
            failures++;
            $display("FAIL event_order: got kind %0d data %0h expected kind %0d data %0h", kind, d, k, ed);
         end
      end
   endtask

   // Per-cycle comparison of the DUT against the expected-event queue.
   logic       p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1;
   logic [7:0] p_data = '0;
   always @(negedge clk) begin
      if (run_chk) begin
         if (!p_rst && p_valid && !p_ready) begin
            chk("hold_valid", 32'(valid), 32'd1);
            chk("hold_data", 32'(data), 32'(p_data));
         end
         if (valid && (!p_valid || p_ready)) begin
            cnt_del++;
            last_del_cyc = cyc;
            expect_evt(K_DEL, data);
         end
         if (ovr) begin
            cnt_ovr++;
            expect_evt(K_OVR, 8'h00);
         end
         if (ferr) begin
            cnt_ferr++;
            expect_evt(K_FERR, 8'h00);
         end
         if (perr) begin
            cnt_perr++;
            expect_evt(K_PERR, 8'h00);
         end
      end
      p_valid = valid;
      p_ready = ready;
      p_rst   = rst;
      p_data  = data;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      tick(DIV);
   endtask

   // Frame outcome decided from content and consumer state, then the frame is driven.
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
      if (!stop_b) begin
         exp_kind.push_back(K_FERR); exp_dat.push_back(8'h00);
      end else if (PAR_EN && (par_b != ^d)) begin
         exp_kind.push_back(K_PERR); exp_dat.push_back(8'h00);
      end else if (m_full) begin
         exp_kind.push_back(K_OVR); exp_dat.push_back(8'h00);
      end else begin
         exp_kind.push_back(K_DEL); exp_dat.push_back(d);
         if (!ready) m_full = 1'b1;
      end
      t_start = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (PAR_EN) send_bit(par_b);
      send_bit(stop_b);
   endtask

   initial begin
      rst   = 1'b1;
      rx    = 1'b1;
      ready = 1'b1;
      tick(3);
      chk("rst_data", 32'(data), 32'h00);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ferr", 32'(ferr), 32'd0);
      chk("rst_ovr", 32'(ovr), 32'd0);
      chk("rst_perr", 32'(perr), 32'd0);
      rst = 1'b0;
      run_chk = 1'b1;
      tick(4);

      // Single frame, consumer ready.
      send_frame(8'hA5, 1'b1, ^8'hA5);
      tick(10);
      chk("a5_latency_in_window", 32'((last_del_cyc - t_start) >= 75 && (last_del_cyc - t_start) <= 82), 32'd1);
      chk("a5_data", 32'(data), 32'hA5);
      chk("a5_valid_pulsed", 32'(valid), 32'd0);
      chk("a5_deliveries", 32'(cnt_del), 32'd1);
      chk("a5_pending", 32'(exp_kind.size()), 32'd0);

      // Overrun with back-to-back frames.
      ready = 1'b0;
      send_frame(8'h12, 1'b1, ^8'h12);
      send_frame(8'h34, 1'b1, ^8'h34);
      tick(10);
      chk("ovr_data_kept", 32'(data), 32'h12);
      chk("ovr_valid_held", 32'(valid), 32'd1);
      chk("ovr_count", 32'(cnt_ovr), 32'd1);
      chk("ovr_pending", 32'(exp_kind.size()), 32'd0);
      ready = 1'b1;
      m_full = 1'b0;
      tick(2);
      chk("ovr_drain_valid", 32'(valid), 32'd0);

      // Framing error followed by a break.
      send_frame(8'h00, 1'b0, 1'b0);
      tick(40);
      rx = 1'b1;
      tick(20);
      chk("brk_ferr_count", 32'(cnt_ferr), 32'd1);
      chk("brk_no_delivery", 32'(cnt_del), 32'd2);
      chk("brk_pending", 32'(exp_kind.size()), 32'd0);
      send_frame(8'h3C, 1'b1, ^8'h3C);
      tick(10);
      chk("after_brk_data", 32'(data), 32'h3C);
      chk("after_brk_pending", 32'(exp_kind.size()), 32'd0);

      // Glitch on the line.
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(20);
      chk("glitch_busy", 32'(busy), 32'd0);
      chk("glitch_no_delivery", 32'(cnt_del), 32'd3);

      // Reset during bit 3 of 0xFF.
      rx = 1'b0;
      tick(DIV);
      rx = 1'b1;
      tick(3 * DIV + DIV / 2);
      chk("midrst_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      chk("midrst_busy_after", 32'(busy), 32'd0);
      tick(60);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_no_delivery", 32'(cnt_del), 32'd3);
      send_frame(8'h81, 1'b1, ^8'h81);
      tick(10);
      chk("after_rst_data", 32'(data), 32'h81);
      chk("after_rst_deliveries", 32'(cnt_del), 32'd4);
      chk("after_rst_errors", 32'(cnt_ferr + cnt_ovr + cnt_perr), 32'd2);

`ifdef UART_RX_SNIFFER_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      tick(10);
      chk("par_err_count", 32'(cnt_perr), 32'd1);
      chk("par_err_no_delivery", 32'(cnt_del), 32'd4);
      send_frame(8'h07, 1'b1, 1'b1);
      tick(10);
      chk("par_ok_data", 32'(data), 32'h07);
      chk("par_pending", 32'(exp_kind.size()), 32'd0);
`endif

      tick(5);
      chk("final_pending", 32'(exp_kind.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
